lut_stim_seq: RTL and testbench

- Hardware stimulus sequencer that sits directly upstream of the 3-input combinational LUT (inputs A, B, C; output F).
- Sweeps every input combination onto the LUT inputs and waits a settle time on each one.
- Samples the LUT output for each combination and assembles the complete truth table in a register.
- Runs free at a prescaled rate (auto mode) or advances one combination per step pulse (step mode), so the sweep can be watched on board LEDs or checked in simulation.

---
 rtl/lut_stim_seq.sv | 132 +++++++++++++
 tb/tb_lut_stim_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_stim_seq.sv
//==============================================================================
// Module      : lut_stim_seq
// Description : Sweeps every input vector onto a small combinational LUT,
//               samples F after a settle time and assembles the truth table.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lut_stim_seq #(
    parameter int N_IN   = 3,
    parameter int DIV    = 50_000_000,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 step,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 cap_valid,
    output logic [2**N_IN-1:0]   truth
);

    localparam int c_NT      = 2**N_IN;
    localparam int c_CNT_MAX = (DIV > SETTLE) ? DIV : SETTLE;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_SETTLE_M1 = c_CNT_W'(SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_M1    = c_CNT_W'(DIV - 1);
    localparam logic [N_IN-1:0]    c_LAST      = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [N_IN-1:0]    r_vec,   w_vec_nxt;
    logic [c_NT-1:0]    r_truth, w_truth_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_done,  w_done_nxt;
    logic               r_cap,   w_cap_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_truth <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vec   <= w_vec_nxt;
            r_truth <= w_truth_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cap   <= w_cap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_nxt   = r_vec;
        w_truth_nxt = r_truth;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_cap_nxt   = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_vec_nxt   = '0;
                    w_truth_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_M1) begin
                    w_truth_nxt[r_vec] = f_in;
                    w_cap_nxt          = 1'b1;
                    w_cnt_nxt          = '0;
                    if (r_vec == c_LAST) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                // Holding cnt at 0 in step mode makes a switch to auto start a fresh dwell.
                if (mode) begin
                    w_cnt_nxt = '0;
                    if (step) begin
                        w_vec_nxt   = r_vec + 1'b1;
                        w_state_nxt = S_SETTLE;
                    end
                end else if (r_cnt == c_DIV_M1) begin
                    w_vec_nxt   = r_vec + 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign vec_out   = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cap_valid = r_cap;
    assign truth     = r_truth;

endmodule

`default_nettype wire

// File: tb/tb_lut_stim_seq.sv
//==============================================================================
// Module      : tb_lut_stim_seq
// Description : Self-checking bench for lut_stim_seq with a timestamp model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lut_stim_seq;

    localparam int DIV    = 4;
    localparam int SETTLE = 2;
    localparam int NT     = 8;

    localparam int PH_IDLE = 0;
    localparam int PH_SET  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_DONE = 3;

    localparam int LUT_ABC   = 0;
    localparam int LUT_ONE   = 1;
    localparam int LUT_GLITCH = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic          step;
    logic          f_in;
    logic [2:0]    vec_out;
    logic          busy;
    logic          done;
    logic          cap_valid;
    logic [NT-1:0] truth;

    int            total = 0;
    int            bad   = 0;
    int            lut_sel = LUT_ABC;
    logic [2:0]    last_vec;

    lut_stim_seq #(.N_IN(3), .DIV(DIV), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .step      (step),
        .f_in      (f_in),
        .vec_out   (vec_out),
        .busy      (busy),
        .done      (done),
        .cap_valid (cap_valid),
        .truth     (truth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // age = cycles since the vector was applied (0 in the first cycle after a change)
    function automatic logic lut_f(input int sel, input logic [2:0] v, input int age);
        case (sel)
            LUT_ABC: return (v[2] & v[1]) | v[0];
            LUT_ONE: return 1'b1;
            default: return (age == 0);
        endcase
    endfunction

    always @(posedge clk) last_vec <= vec_out;
    assign f_in = lut_f(lut_sel, vec_out, (vec_out != last_vec) ? 0 : 1);

    // Model: each vector is applied at an edge index, captured SETTLE edges later,
    // and in auto mode the next vector follows DIV edges after the capture.
    typedef struct packed {
        int            k;
        int            phase;
        int            vec;
        int            apply_k;
        int            wait_from;
        logic [NT-1:0] truth;
        logic          busy;
        logic          done;
        logic          cap;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t c, input logic st,
                                          input logic md, input logic sp, input int sel);
        model_t n;
        n     = c;
        n.k   = c.k + 1;
        n.cap = 1'b0;
        case (c.phase)
            PH_IDLE, PH_DONE: begin
                if (st) begin
                    n.vec = 0; n.truth = '0; n.busy = 1'b1; n.done = 1'b0;
                    n.apply_k = n.k; n.phase = PH_SET;
                end
            end
            PH_SET: begin
                if (n.k - c.apply_k == SETTLE) begin
                    n.truth[c.vec] = lut_f(sel, 3'(c.vec), n.k - c.apply_k - 1);
                    n.cap = 1'b1;
                    if (c.vec == NT - 1) begin
                        n.busy = 1'b0; n.done = 1'b1; n.phase = PH_DONE;
                    end else begin
                        n.phase = PH_WAIT; n.wait_from = n.k + 1;
                    end
                end
            end
            default: begin
                if (md) begin
                    n.wait_from = n.k + 1;
                    if (sp) begin
                        n.vec = c.vec + 1; n.apply_k = n.k; n.phase = PH_SET;
                    end
                end else if (n.k - c.wait_from == DIV - 1) begin
                    n.vec = c.vec + 1; n.apply_k = n.k; n.phase = PH_SET;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, start, mode, step, lut_sel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_vec",   32'(vec_out),   32'(m.vec));
            chk("model_busy",  32'(busy),      32'(m.busy));
            chk("model_done",  32'(done),      32'(m.done));
            chk("model_cap",   32'(cap_valid), 32'(m.cap));
            chk("model_truth", 32'(truth),     32'(m.truth));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_done", 32'(done), 32'd1);
        tick();
    endtask

    // Pulses start, then counts busy cycles and captures until done;
    // start is pulsed again after restart_at cycles (negative = never).
    task automatic sweep_measure(input int restart_at, output int busy_n, output int cap_n);
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_n = 0;
        cap_n  = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (cap_valid) cap_n++;
            start = (n == restart_at);
            if (done) break;
        end
        start = 1'b0;
        chk("sweep_done", 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        int bn;
        int cn;
        int n;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; step = 1'b0;
        tick(); tick();
        chk("rst_vec",   32'(vec_out),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_cap",   32'(cap_valid), 32'd0);
        chk("rst_truth", 32'(truth),     32'd0);
        rst_n = 1'b1;
        tick();

        // Auto sweep with F = (A&B)|C
        sweep_measure(-1, bn, cn);
        chk("auto_busy_cycles", 32'(bn), 32'd44);
        chk("auto_caps",        32'(cn), 32'd8);
        chk("auto_truth",       32'(truth), 32'hEA);
        chk("auto_vec_final",   32'(vec_out), 32'd7);

        // Step mode from DONE
        mode  = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            repeat (10) tick();
            chk("step_hold", 32'(vec_out), 32'(i - 1));
            step = 1'b1; tick(); step = 1'b0;
            chk("step_adv", 32'(vec_out), 32'(i));
        end
        tick();
        chk("step_done_early", 32'(done), 32'd0);
        tick();
        chk("step_done", 32'(done), 32'd1);
        chk("step_truth", 32'(truth), 32'hEA);
        mode = 1'b0;

        // Reset mid-sweep while vec_out == 3
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (vec_out != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec3", 32'(vec_out), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_vec",   32'(vec_out),   32'd0);
        chk("async_truth", 32'(truth),     32'd0);
        chk("async_busy",  32'(busy),      32'd0);
        chk("async_done",  32'(done),      32'd0);
        chk("async_cap",   32'(cap_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // step in IDLE is ignored
        step = 1'b1; tick(); step = 1'b0;
        repeat (3) tick();
        chk("idle_step_vec",  32'(vec_out), 32'd0);
        chk("idle_step_busy", 32'(busy),    32'd0);

        // start and step together in IDLE: start wins
        start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
        chk("ss_busy", 32'(busy), 32'd1);
        repeat (5) tick();
        chk("ss_vec_hold", 32'(vec_out), 32'd0);
        tick();
        chk("ss_vec_adv", 32'(vec_out), 32'd1);
        wait_done(200);
        chk("reset_rerun_truth", 32'(truth), 32'hEA);

        // start while busy is ignored
        sweep_measure(10, bn, cn);
        chk("restart_busy_cycles", 32'(bn), 32'd44);
        chk("restart_truth",       32'(truth), 32'hEA);

        // Re-run from DONE with F = 1
        lut_sel = LUT_ONE;
        start = 1'b1; tick(); start = 1'b0;
        chk("rerun_truth_clr", 32'(truth), 32'd0);
        chk("rerun_done_clr",  32'(done),  32'd0);
        wait_done(200);
        chk("rerun_truth", 32'(truth), 32'hFF);

        // F glitches high only in the first cycle after each vector change
        lut_sel = LUT_GLITCH;
        start = 1'b1; tick(); start = 1'b0;
        wait_done(200);
        chk("settle_truth", 32'(truth), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
